// File: rtl/wb_traffic_gen_pkg.sv
// Shared types and constants for the Wishbone burst traffic generator:
// FSM state encoding, cycle-type identifiers and per-width LFSR tap masks.
package wb_traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    WR_GAP   = 3'd2,
    RD_BURST = 3'd3,
    RD_GAP   = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  // Right-shift Galois feedback masks; unsupported widths get no feedback.
  function automatic logic [63:0] lfsr_taps(input int dw);
    case (dw)
      8:       lfsr_taps = 64'h0000_0000_0000_00B8;
      16:      lfsr_taps = 64'h0000_0000_0000_B400;
      32:      lfsr_taps = 64'h0000_0000_8020_0003;
      64:      lfsr_taps = 64'hD800_0000_0000_0000;
      default: lfsr_taps = 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/wb_tg_lfsr.sv
// Galois LFSR used both to generate write data and to regenerate the
// expected read data; load has priority over step.
module wb_tg_lfsr
  import wb_traffic_gen_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          step,
  output logic [DW-1:0] value
);

  localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

  logic [DW-1:0] value_q, value_d;

  // Next LFSR value: reload, single Galois step, or hold.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves value_d unassigned (that would infer a latch).
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  // LFSR state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (wb_rst_i) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone B3 burst master with built-in read-back checker: writes
// cfg_num_bursts incrementing bursts of LFSR data, then reads the same range
// and counts mismatches. All Wishbone outputs come straight from flops.
// Optional feature macro: WBTG_TIMEOUT_EN (ack timeout, aborts to FIN).
module wb_traffic_gen
  import wb_traffic_gen_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int BLW    = 5,
  parameter int TO_CYC = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base_addr,
  input  logic [15:0]     cfg_num_bursts,
  input  logic [BLW-1:0]  cfg_bl,
  input  logic [DW-1:0]   cfg_seed,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt,
  output logic [AW-1:0]   first_err_addr,
  output logic            timeout_o
);

  localparam int             SW        = DW / 8;
  localparam logic [AW-1:0]  ADDR_STEP = AW'(SW);
  localparam logic [BLW-1:0] BL_ONE    = BLW'(1);

  state_t         state_q, state_d;
  logic [AW-1:0]  base_q, base_d, addr_q, addr_d, ferr_q, ferr_d;
  logic [15:0]    nb_q, nb_d, burst_q, burst_d, err_q, err_d;
  logic [BLW-1:0] bl_q, bl_d, beat_q, beat_d;
  logic [DW-1:0]  seed_q, seed_d;
  logic           cyc_q, cyc_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]     cti_q, cti_d;

  logic           lfsr_load, lfsr_step;
  logic [DW-1:0]  lfsr_seed, lfsr_val;
  logic           accept, last_beat, timeout_hit;

  // A beat is taken only while the strobe is up; stray acks are ignored.
  assign accept    = cyc_q & wb_ack_i;
  assign last_beat = (beat_q == (bl_q - BL_ONE));

  wb_tg_lfsr #(.DW(DW)) u_lfsr (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (lfsr_load),
    .seed     (lfsr_seed),
    .step     (lfsr_step),
    .value    (lfsr_val)
  );

`ifdef WBTG_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYC + 1);

  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;

  assign timeout_hit = cyc_q && !wb_ack_i && (to_cnt_q == TOW'(TO_CYC - 1));

  // Wait counter runs only while a strobe is unanswered; sticky flag clears on start.
  always_comb begin
    to_cnt_d  = (cyc_q && !wb_ack_i && !timeout_hit) ? to_cnt_q + TOW'(1) : '0;
    timeout_d = timeout_q;
    if (state_q == IDLE && start) timeout_d = 1'b0;
    if (timeout_hit)              timeout_d = 1'b1;
  end

  // Timeout counter and sticky flag registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Control FSM, address/beat/burst counters, checker and registered-output decode.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    nb_d      = nb_q;
    bl_d      = bl_q;
    seed_d    = seed_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    lfsr_seed = seed_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = cfg_base_addr;
          addr_d    = cfg_base_addr;
          nb_d      = cfg_num_bursts;
          bl_d      = (cfg_bl == '0) ? BL_ONE : cfg_bl;
          seed_d    = (cfg_seed == '0) ? '1 : cfg_seed;
          beat_d    = '0;
          burst_d   = '0;
          err_d     = '0;
          ferr_d    = '0;
          lfsr_load = 1'b1;
          lfsr_seed = (cfg_seed == '0) ? '1 : cfg_seed;
          state_d   = (cfg_num_bursts == 16'd0) ? FIN : WR_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        if (timeout_hit) begin
          state_d = FIN;
        end else if (accept) begin
          addr_d    = addr_q + ADDR_STEP;
          lfsr_step = 1'b1;
          if (state_q == RD_BURST && wb_dat_i != lfsr_val) begin
            if (err_q == 16'd0)     ferr_d = addr_q;
            if (err_q != 16'hFFFF)  err_d  = err_q + 16'd1;
          end
          if (last_beat) begin
            beat_d  = '0;
            burst_d = burst_q + 16'd1;
            state_d = (state_q == WR_BURST) ? WR_GAP : RD_GAP;
          end else begin
            beat_d  = beat_q + BL_ONE;
          end
        end
      end
      WR_GAP: begin
        if (burst_q == nb_q) begin
          // Read phase replays the write pattern from the top of the range.
          burst_d   = '0;
          addr_d    = base_q;
          lfsr_load = 1'b1;
          state_d   = RD_BURST;
        end else begin
          state_d   = WR_BURST;
        end
      end
      RD_GAP:  state_d = (burst_q == nb_q) ? FIN : RD_BURST;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cyc_d  = (state_d == WR_BURST) || (state_d == RD_BURST);
    we_d   = (state_d == WR_BURST);
    cti_d  = 3'b000;
    if (cyc_d) cti_d = (beat_d == (bl_d - BL_ONE)) ? CTI_EOB : CTI_INCR;
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      nb_q    <= '0;
      bl_q    <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cti_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      bl_q    <= bl_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      cti_q   <= cti_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_addr_o      = addr_q;
  assign wb_dat_o       = lfsr_val;
  assign wb_sel_o       = {SW{cyc_q}};
  assign wb_cti_o       = cti_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: doc/wb_traffic_gen.md
# wb_traffic_gen

Synthesizable Wishbone B3 burst master with built-in data checker. It drives the same Wishbone slave port that `sdrc_top` exposes (`wb_*` signals) and replaces bench-side scripted write/read FIFOs with a self-contained engine:
- **Write phase:** N incrementing bursts of pseudo-random data.
- **Read phase:** the same address range is read back and compared against the regenerated pattern.

Width, address size and burst length are parametrised. It serves both as a bench stimulus source and as an on-chip memory self-test.

## Interface
Parameters:
- DW, 32, Wishbone data width (8/16/32/64).
- AW, 26, Wishbone byte-address width.
- BLW, 5, width of burst-length field; max beats per burst 2^BLW-1.
- TO_CYC, 255, ack-timeout cycle count (used only with WBTG_TIMEOUT_EN).

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; ignored while busy.
- cfg_base_addr  in  AW  first byte address; sampled on start.
- cfg_num_bursts  in  16  bursts per phase; sampled on start.
- cfg_bl  in  BLW  beats per burst; 0 treated as 1; sampled on start.
- cfg_seed  in  DW  LFSR seed; sampled on start.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe and write enable.
- wb_addr_o  out  AW  byte address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte selects.
- wb_cti_o  out  3  cycle-type identifier.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  read data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err_cnt  out  16  saturating mismatch count.
- first_err_addr  out  AW  address of the first mismatch.
- timeout_o  out  1  sticky ack-timeout flag.

## Operation
- FSM states: IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FIN.
- **IDLE, start = 1:**
  - Latch the cfg_* inputs.
  - Clear err_cnt, first_err_addr and timeout_o.
  - Load the LFSR with cfg_seed. A seed of 0 is replaced by all-ones.
  - Load the address register with cfg_base_addr.
  - Next state is WR_BURST, or FIN if cfg_num_bursts = 0.
- **WR_BURST:**
  - cyc = stb = we = 1, sel = all ones, dat_o = current LFSR value.
  - On each ack: the address advances by DW/8 (modulo 2^AW), the LFSR steps once, and the beat count increments.
  - On the last beat's ack: go to WR_GAP.
- **WR_GAP:**
  - cyc = stb = 0 for exactly one cycle.
  - Next state is WR_BURST, or RD_BURST once all bursts are written.
  - On entry to the read phase, the LFSR reloads the latched seed and the address reloads cfg_base_addr.
- **RD_BURST:**
  - cyc = stb = 1, we = 0.
  - On each ack, compare wb_dat_i with the LFSR value.
  - On mismatch: err_cnt increments, saturating at 16'hFFFF. The first mismatch also captures wb_addr_o into first_err_addr.
  - The address and LFSR then advance as in the write phase.
- **RD_GAP:** mirror of WR_GAP; after the last burst, go to FIN.
- **FIN:** done = 1 for one cycle, then IDLE. err_cnt, first_err_addr and timeout_o hold their values until the next start.
- **cti:** 3'b010 on non-final beats, 3'b111 on the final beat. A single-beat burst uses 3'b111.
- **LFSR:** Galois LFSR of width DW, one step per accepted beat. The tap mask comes from the package, per DW.

## Timing
- **Reset:** all outputs are 0 and the FSM is in IDLE.
  - Asserting reset mid-burst drops cyc/stb in the same instant (asynchronous).
  - No done pulse is produced.
- **Outputs:** all Wishbone outputs are registered. For start in cycle N, busy and cyc/stb are asserted in N+1.
- **Handshake:**
  - stb and all qualifiers stay stable until an ack is seen on a rising edge.
  - A beat is accepted on the edge where stb & ack is true. The next beat is presented on the following cycle, so throughput is at most one beat per cycle.
  - An ack while stb = 0 is ignored.
- **Burst cycle count:** a burst of B beats with single-cycle ack takes B cycles plus 1 gap cycle.
- **start:** a start pulse while busy is dropped, not queued.

## Configuration
- Macro: WBTG_TIMEOUT_EN.
- **Defined:** a counter runs while stb = 1 and ack = 0.
  - When the counter reaches TO_CYC, cyc/stb drop, timeout_o is set, and the FSM goes to FIN (done pulses).
  - The counter clears on every ack.
- **Undefined:** the block waits indefinitely for ack, and timeout_o is tied to 0.

## Structure
- Package wb_traffic_gen_pkg:
  - state enum;
  - CTI constants (CTI_INCR = 3'b010, CTI_EOB = 3'b111);
  - function returning the LFSR tap mask per width (8: 8'hB8, 16: 16'hB400, 32: 32'h80200003, 64: 64'hD800000000000000).
- Sub-module wb_tg_lfsr (parameter DW): inputs load, seed, step; output value.
  - Two instances are not needed: a single instance is reloaded between phases.

## Test plan
- **Clean pass:** DW = 32, base 0x100, 4 bursts × 8 beats, seed 0x1, zero-wait-state memory model.
  - Required: 32 writes at 0x100..0x17C, then 32 reads; err_cnt = 0; done pulse.
  - Required: phase length of 36 cycles each.
- **Injected fault:** as above, but the model flips bit 0 on the read at 0x110.
  - Required: err_cnt = 1, first_err_addr = 0x110.
- **Wait states:** random ack delays of 0–5 cycles.
  - Required: stb and addr are stable while waiting; the result matches the clean run.
- **Edge configurations:**
  - cfg_bl = 0: every beat carries cti = 3'b111.
  - cfg_num_bursts = 0: done pulses 2 cycles after start, with no Wishbone cycle issued.
  - Base 0x3FFFFFC with 2 beats: the address wraps to 0x0000000.
- **Reset mid-burst:** assert wb_rst_i on the 3rd write beat.
  - Required: cyc/stb go to 0 immediately, busy = 0, and no done pulse.
- **Timeout (WBTG_TIMEOUT_EN defined):** the slave never acks.
  - Required: after 255 cycles, timeout_o = 1 and done pulses.
